// File: rtl/pmem_loader_if.sv
// pmem_loader_if: groups the program-load handshake and the CPU-side
// fetch/control signals of pmem_loader.
//   master modport : load host / CPU side (drives ld_start, ld_abort, ld_valid,
//                    ld_data, run_en, fetch_addr; observes the rest)
//   slave modport  : pmem_loader itself
interface pmem_loader_if;
    logic       ld_start;   // single-cycle request to begin a 16-word session
    logic       ld_abort;   // terminates an active session
    logic       ld_valid;   // ld_data holds a valid program byte
    logic [7:0] ld_data;    // {opcode[7:4], imm[3:0]}
    logic       ld_ready;   // loader accepts a byte this cycle
    logic [3:0] ld_addr;    // word index of the next accepted byte
    logic       ld_busy;    // session in progress
    logic       ld_done;    // one-cycle pulse after a completed load
    logic       run_en;     // external permission for the CPU to run
    logic [3:0] fetch_addr; // CPU program counter
    logic [7:0] fetch_data; // instruction word at fetch_addr
    logic       cpu_run;    // CPU clock enable
    logic       cpu_rst_n;  // active-low CPU reset

    modport master (
        output ld_start, ld_abort, ld_valid, ld_data, run_en, fetch_addr,
        input  ld_ready, ld_addr, ld_busy, ld_done, fetch_data, cpu_run, cpu_rst_n
    );

    modport slave (
        input  ld_start, ld_abort, ld_valid, ld_data, run_en, fetch_addr,
        output ld_ready, ld_addr, ld_busy, ld_done, fetch_data, cpu_run, cpu_rst_n
    );
endinterface

// File: rtl/pmem_loader.sv
// pmem_loader: 16 x 8-bit program memory with a byte-serial loader.
// A load session (ld_start) writes 16 bytes over a valid/ready handshake,
// holding the CPU in reset while it runs; ld_abort ends it early keeping the
// words already written. The CPU fetches combinationally at any time.
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset (memory back to FILL)
//   bus     : pmem_loader_if.slave (load handshake, fetch port, CPU control)
module pmem_loader #(
    parameter logic [7:0] FILL = 8'hF0  // JMP_Im 0: self-loop at address 0
) (
    input logic          clk,
    input logic          reset_n,
    pmem_loader_if.slave bus
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StLoad = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0] state_q, state_d;
    logic [3:0] wcnt_q, wcnt_d;
    logic [7:0] mem_q [16];
    logic       wr_en;

    // Abort outranks a same-cycle transfer; start is only honoured in idle.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        wr_en   = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.ld_start) begin
                    state_d = StLoad;
                    wcnt_d  = 4'd0;
                end
            end
            StLoad: begin
                if (bus.ld_abort) begin
                    state_d = StIdle;
                end else if (bus.ld_valid) begin
                    wr_en  = 1'b1;
                    wcnt_d = wcnt_q + 4'd1;  // wraps 15 -> 0 on the last word
                    if (wcnt_q == 4'd15) begin
                        state_d = StDone;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            wcnt_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) begin
                mem_q[i] <= FILL;
            end
        end else if (wr_en) begin
            mem_q[wcnt_q] <= bus.ld_data;
        end
    end

    logic in_session;
    assign in_session = (state_q == StLoad) || (state_q == StDone);

    assign bus.ld_ready   = (state_q == StLoad);
    assign bus.ld_busy    = in_session;
    assign bus.ld_done    = (state_q == StDone);
    assign bus.ld_addr    = wcnt_q;
    assign bus.fetch_data = mem_q[bus.fetch_addr];
    // CPU reset is decoded from registered state, so it only changes on clk
    // edges (or goes high asynchronously with reset_n).
    assign bus.cpu_rst_n  = !in_session;
    assign bus.cpu_run    = !in_session && bus.run_en;

endmodule

// File: tb/tb_pmem_loader.sv
`timescale 1ns/1ps
module tb_pmem_loader;

    localparam logic [7:0] Fill = 8'hF0;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    pmem_loader_if bus();

    pmem_loader #(.FILL(Fill)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;
    int done_seen = 0;

    // Reference model: program image plus session bookkeeping.
    logic [7:0] mref [16];
    bit         busy_m;
    bit         done_m;
    int         widx;

    always @(negedge clk) if (bus.ld_done === 1'b1) done_seen++;

    task automatic set_idle();
        bus.ld_start = 1'b0;
        bus.ld_abort = 1'b0;
        bus.ld_valid = 1'b0;
        bus.ld_data  = 8'h00;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mref[i] = Fill;
        busy_m = 0;
        done_m = 0;
        widx   = 0;
    endtask

    // Advance the model by one clock using the current inputs, then let the DUT clock.
    task automatic tick();
        if (reset_n) begin
            if (done_m) begin
                done_m = 0;
                busy_m = 0;
            end else if (busy_m) begin
                if (bus.ld_abort) begin
                    busy_m = 0;
                end else if (bus.ld_valid) begin
                    mref[widx] = bus.ld_data;
                    if (widx == 15) done_m = 1;
                    widx = (widx + 1) % 16;
                end
            end else if (bus.ld_start) begin
                busy_m = 1;
                widx   = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        set_idle();
        reset_n = 1'b0;
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus.run_en = 1'b1;
        bus.fetch_addr = 4'd0;
        set_idle();
        reset_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({bus.ld_ready, bus.ld_busy, bus.ld_done, bus.cpu_rst_n, bus.cpu_run, bus.ld_addr}
            !== {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0}) begin
            n_fails++;
            $display("FAIL reset_outputs got %b%b%b%b%b addr %0d want 00011 addr 0",
                     bus.ld_ready, bus.ld_busy, bus.ld_done, bus.cpu_rst_n, bus.cpu_run,
                     bus.ld_addr);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            bus.fetch_addr = 4'(i);
            #0.1;
            n_checks++;
            if (bus.fetch_data !== 8'hF0) begin
                n_fails++;
                $display("FAIL reset_fill addr %0d got %h want f0", i, bus.fetch_data);
            end
        end
        n_checks++;
        if ({bus.cpu_run, bus.cpu_rst_n, bus.ld_ready} !== 3'b110) begin
            n_fails++;
            $display("FAIL reset_release run/rst_n/ready got %b%b%b want 110",
                     bus.cpu_run, bus.cpu_rst_n, bus.ld_ready);
        end
        bus.run_en = 1'b0;
        #1;
        n_checks++;
        if (bus.cpu_run !== 1'b0) begin
            n_fails++;
            $display("FAIL idle_run_en_low cpu_run got %b want 0", bus.cpu_run);
        end
        bus.run_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int d0;
        do_reset();
        d0 = done_seen;
        bus.ld_start = 1'b1;
        tick();
        bus.ld_start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bus.ld_valid = 1'b1;
            bus.ld_data  = (i == 15) ? 8'hF0 : 8'hB0 + 8'(i);
            #1;
            n_checks++;
            if ({bus.ld_ready, bus.cpu_rst_n, bus.cpu_run, bus.ld_addr} !== {3'b100, 4'(i)}) begin
                n_fails++;
                $display("FAIL b2b_load step %0d ready/rst_n/run %b%b%b addr %0d want 100 addr %0d",
                         i, bus.ld_ready, bus.cpu_rst_n, bus.cpu_run, bus.ld_addr, i);
            end
            tick();
        end
        set_idle();
        #1;
        n_checks++;
        if ({bus.ld_done, bus.ld_busy, bus.ld_ready, bus.cpu_rst_n} !== 4'b1100) begin
            n_fails++;
            $display("FAIL b2b_done done/busy/ready/rst_n got %b%b%b%b want 1100",
                     bus.ld_done, bus.ld_busy, bus.ld_ready, bus.cpu_rst_n);
        end
        tick();
        #1;
        n_checks++;
        if ({bus.ld_done, bus.ld_busy, bus.cpu_rst_n, bus.cpu_run} !== 4'b0011) begin
            n_fails++;
            $display("FAIL b2b_after done/busy/rst_n/run got %b%b%b%b want 0011",
                     bus.ld_done, bus.ld_busy, bus.cpu_rst_n, bus.cpu_run);
        end
        bus.fetch_addr = 4'd5;
        #1;
        n_checks++;
        if (bus.fetch_data !== 8'hB5) begin
            n_fails++;
            $display("FAIL b2b_word5 got %h want b5", bus.fetch_data);
        end
        n_checks++;
        if (done_seen - d0 != 1) begin
            n_fails++;
            $display("FAIL b2b_done_count got %0d want 1", done_seen - d0);
        end
        @(negedge clk);
    endtask

    task automatic test_gaps();
        int d0;
        do_reset();
        d0 = done_seen;
        bus.ld_start = 1'b1;
        tick();
        bus.ld_start = 1'b0;
        for (int c = 0; c < 32; c++) begin
            bus.ld_valid = (c % 2 == 0);
            bus.ld_data  = (c / 2 == 15) ? 8'hF0 : 8'hB0 + 8'(c / 2);
            #1;
            n_checks++;
            if ({bus.ld_ready, bus.ld_done, bus.ld_addr} !==
                {(c != 31), (c == 31), 4'(((c + 1) / 2) % 16)}) begin
                n_fails++;
                $display("FAIL gaps_step cycle %0d ready/done %b%b addr %0d want %b%b addr %0d",
                         c, bus.ld_ready, bus.ld_done, bus.ld_addr, (c != 31), (c == 31),
                         ((c + 1) / 2) % 16);
            end
            tick();
        end
        set_idle();
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            bus.fetch_addr = 4'(i);
            #0.1;
            n_checks++;
            if (bus.fetch_data !== ((i == 15) ? 8'hF0 : 8'hB0 + 8'(i))) begin
                n_fails++;
                $display("FAIL gaps_word %0d got %h want %h", i, bus.fetch_data,
                         (i == 15) ? 8'hF0 : 8'hB0 + 8'(i));
            end
        end
        n_checks++;
        if (done_seen - d0 != 1) begin
            n_fails++;
            $display("FAIL gaps_done_count got %0d want 1", done_seen - d0);
        end
        @(negedge clk);
    endtask

    task automatic test_abort();
        logic [7:0] bytes [3];
        logic [7:0] want [4];
        int d0;
        bytes[0] = 8'h31; bytes[1] = 8'h52; bytes[2] = 8'h93;
        want[0] = 8'h31; want[1] = 8'h52; want[2] = 8'h93; want[3] = 8'hF0;
        do_reset();
        d0 = done_seen;
        bus.ld_start = 1'b1;
        tick();
        bus.ld_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.ld_valid = 1'b1;
            bus.ld_data  = bytes[i];
            tick();
        end
        bus.ld_abort = 1'b1;
        bus.ld_valid = 1'b1;
        bus.ld_data  = 8'hEE;
        tick();
        set_idle();
        #1;
        n_checks++;
        if ({bus.ld_busy, bus.ld_ready, bus.ld_done, bus.cpu_rst_n} !== 4'b0001) begin
            n_fails++;
            $display("FAIL abort_idle busy/ready/done/rst_n got %b%b%b%b want 0001",
                     bus.ld_busy, bus.ld_ready, bus.ld_done, bus.cpu_rst_n);
        end
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            bus.fetch_addr = 4'(i);
            #0.1;
            n_checks++;
            if (bus.fetch_data !== want[i]) begin
                n_fails++;
                $display("FAIL abort_word %0d got %h want %h", i, bus.fetch_data, want[i]);
            end
        end
        n_checks++;
        if (done_seen != d0) begin
            n_fails++;
            $display("FAIL abort_no_done got %0d pulses want 0", done_seen - d0);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_load();
        int d0;
        do_reset();
        d0 = done_seen;
        bus.ld_start = 1'b1;
        tick();
        bus.ld_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.ld_valid = 1'b1;
            bus.ld_data  = 8'($urandom);
            tick();
        end
        set_idle();
        reset_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({bus.ld_busy, bus.cpu_rst_n, bus.ld_addr} !== {2'b01, 4'd0}) begin
            n_fails++;
            $display("FAIL rst_mid_async busy/rst_n %b%b addr %0d want 01 addr 0",
                     bus.ld_busy, bus.cpu_rst_n, bus.ld_addr);
        end
        for (int i = 0; i < 16; i++) begin
            bus.fetch_addr = 4'(i);
            #0.1;
            n_checks++;
            if (bus.fetch_data !== 8'hF0) begin
                n_fails++;
                $display("FAIL rst_mid_fill addr %0d got %h want f0", i, bus.fetch_data);
            end
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (done_seen != d0) begin
            n_fails++;
            $display("FAIL rst_mid_no_done got %0d pulses want 0", done_seen - d0);
        end
        @(negedge clk);
    endtask

    task automatic test_start_ignored();
        do_reset();
        // Start and abort together in idle: start wins.
        bus.ld_start = 1'b1;
        bus.ld_abort = 1'b1;
        tick();
        set_idle();
        #1;
        n_checks++;
        if ({bus.ld_busy, bus.ld_ready} !== 2'b11) begin
            n_fails++;
            $display("FAIL start_beats_abort busy/ready got %b%b want 11",
                     bus.ld_busy, bus.ld_ready);
        end
        for (int i = 0; i < 6; i++) begin
            bus.ld_valid = 1'b1;
            bus.ld_data  = 8'h60 + 8'(i);
            tick();
        end
        bus.ld_valid = 1'b0;
        bus.ld_start = 1'b1;
        tick();
        bus.ld_start = 1'b0;
        #1;
        n_checks++;
        if ({bus.ld_busy, bus.ld_addr} !== {1'b1, 4'd6}) begin
            n_fails++;
            $display("FAIL start_in_load busy %b addr %0d want 1 addr 6",
                     bus.ld_busy, bus.ld_addr);
        end
        bus.ld_valid = 1'b1;
        bus.ld_data  = 8'h66;
        tick();
        set_idle();
        #1;
        n_checks++;
        if (bus.ld_addr !== 4'd7) begin
            n_fails++;
            $display("FAIL start_in_load_next addr got %0d want 7", bus.ld_addr);
        end
        bus.ld_abort = 1'b1;
        tick();
        set_idle();
        // Valid while not ready must not write.
        bus.ld_valid = 1'b1;
        bus.ld_data  = 8'h77;
        repeat (3) tick();
        set_idle();
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            bus.fetch_addr = 4'(i);
            #0.1;
            n_checks++;
            if (bus.fetch_data !== ((i < 7) ? 8'h60 + 8'(i) : 8'hF0)) begin
                n_fails++;
                $display("FAIL idle_valid_nowrite word %0d got %h want %h", i, bus.fetch_data,
                         (i < 7) ? 8'h60 + 8'(i) : 8'hF0);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [18:0] exp_v;
        logic [18:0] got_v;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            bus.ld_start   = ($urandom_range(0, 15) == 0);
            bus.ld_abort   = ($urandom_range(0, 59) == 0);
            bus.ld_valid   = ($urandom_range(0, 2) != 0);
            bus.ld_data    = 8'($urandom);
            bus.fetch_addr = 4'($urandom);
            bus.run_en     = ($urandom_range(0, 3) != 0);
            #1;
            exp_v = {busy_m && !done_m, busy_m, done_m, !busy_m, !busy_m && bus.run_en,
                     4'(widx), mref[bus.fetch_addr]};
            got_v = {bus.ld_ready, bus.ld_busy, bus.ld_done, bus.cpu_rst_n, bus.cpu_run,
                     bus.ld_addr, bus.fetch_data};
            n_checks++;
            if (got_v !== exp_v) begin
                n_fails++;
                $display("FAIL random cycle %0d {ready,busy,done,rst_n,run,addr,data} got %h want %h",
                         c, got_v, exp_v);
            end
            tick();
        end
        set_idle();
        bus.run_en = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        set_idle();
        bus.run_en = 1'b1;
        bus.fetch_addr = 4'd0;
        model_reset();
        test_reset();
        test_back_to_back();
        test_gaps();
        test_abort();
        test_reset_mid_load();
        test_start_ignored();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
